// File: rtl/d_prob_sched_if.sv
// rtl/d_prob_sched_if.sv - score RAM, d_prob datapath and (idx, d) output stream bundle
interface d_prob_sched_if #(
  parameter int T_WIDTH = 8,
  parameter int IDX_W   = 4
);
  logic               sc_rd_en;
  logic [IDX_W-1:0]   sc_addr;
  logic [T_WIDTH:0]   sc_data;
  logic [T_WIDTH:0]   dp_T;
  logic [T_WIDTH:0]   dp_q;
  logic [T_WIDTH:0]   dp_v;
  logic [T_WIDTH-1:0] dp_d;
  logic               out_valid;
  logic               out_ready;
  logic [IDX_W-1:0]   out_idx;
  logic [T_WIDTH-1:0] out_d;

  modport master (
    output sc_rd_en, sc_addr, dp_T, dp_q, dp_v, out_valid, out_idx, out_d,
    input  sc_data, dp_d, out_ready
  );

  modport slave (
    input  sc_rd_en, sc_addr, dp_T, dp_q, dp_v, out_valid, out_idx, out_d,
    output sc_data, dp_d, out_ready
  );
endinterface

// File: rtl/d_prob_sched.sv
// rtl/d_prob_sched.sv - sequences one shared d_prob datapath over all classes of a sample
module d_prob_sched #(
  parameter int T_WIDTH = 8,
  parameter int N_CLASS = 10,
  parameter int IDX_W   = 4,
  parameter int SUM_W   = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [IDX_W-1:0]   label,
  input  logic [T_WIDTH:0]   t_cfg,
  output logic               busy,
  output logic               done,
  output logic               lbl_err,
  output logic [SUM_W-1:0]   err_sum,
  d_prob_sched_if.master     bus
);

  localparam int EW = ((SUM_W > T_WIDTH) ? SUM_W : T_WIDTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_CLASS - 1);
  localparam logic [IDX_W:0]   N_CLASS_EXT = (IDX_W + 1)'(N_CLASS);
  localparam logic [SUM_W-1:0] SUM_MAX     = {SUM_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_MEM, S_CALC, S_CAP, S_EMIT, S_FIN
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] label_q;
  logic [EW-1:0]    sum_ext;
  logic [SUM_W-1:0] sum_sat;

  // One extra bit of headroom so a single d can never wrap the accumulator before the clamp
  always_comb begin
    sum_ext = EW'(err_sum) + EW'(bus.dp_d);
    sum_sat = (sum_ext > EW'(SUM_MAX)) ? SUM_MAX : sum_ext[SUM_W-1:0];
  end

  assign bus.sc_addr = busy ? idx : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      idx           <= '0;
      label_q       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      lbl_err       <= 1'b0;
      err_sum       <= '0;
      bus.sc_rd_en  <= 1'b0;
      bus.dp_T      <= '0;
      bus.dp_q      <= '0;
      bus.dp_v      <= '0;
      bus.out_valid <= 1'b0;
      bus.out_idx   <= '0;
      bus.out_d     <= '0;
    end else begin
      done         <= 1'b0;
      bus.sc_rd_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            label_q  <= label;
            bus.dp_T <= t_cfg;
            idx      <= '0;
            err_sum  <= '0;
            busy     <= 1'b1;
            if ({1'b0, label} < N_CLASS_EXT) begin
              lbl_err      <= 1'b0;
              bus.sc_rd_en <= 1'b1;
              state        <= S_RD;
            end else begin
              lbl_err <= 1'b1;
              done    <= 1'b1;
              state   <= S_FIN;
            end
          end
        end
        S_RD: state <= S_MEM;
        S_MEM: begin
          bus.dp_v <= bus.sc_data;
          bus.dp_q <= (idx == label_q) ? {{T_WIDTH{1'b0}}, 1'b1} : '0;
          state    <= S_CALC;
        end
        S_CALC: state <= S_CAP;
        S_CAP: begin
          bus.out_d     <= bus.dp_d;
          bus.out_idx   <= idx;
          err_sum       <= sum_sat;
          bus.out_valid <= 1'b1;
          state         <= S_EMIT;
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              idx          <= idx + 1'b1;
              bus.sc_rd_en <= 1'b1;
              state        <= S_RD;
            end
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_d_prob_sched.sv
// tb/tb_d_prob_sched.sv - directed bench for d_prob_sched with score RAM and d_prob model
module tb_d_prob_sched;
  localparam int TW = 8;
  localparam int IW = 3;
  localparam int NC = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, start, out_ready;
  logic [IW-1:0]  label;
  logic [TW:0]    t_cfg;
  logic           busy_a, done_a, lbl_err_a;
  logic [11:0]    err_sum_a;
  logic           busy_b, done_b, lbl_err_b;
  logic [5:0]     err_sum_b;

  d_prob_sched_if #(.T_WIDTH(TW), .IDX_W(IW)) bus_a ();
  d_prob_sched_if #(.T_WIDTH(TW), .IDX_W(IW)) bus_b ();
  assign bus_a.out_ready = out_ready;
  assign bus_b.out_ready = out_ready;

  d_prob_sched #(.T_WIDTH(TW), .N_CLASS(NC), .IDX_W(IW), .SUM_W(12)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .label(label), .t_cfg(t_cfg),
    .busy(busy_a), .done(done_a), .lbl_err(lbl_err_a), .err_sum(err_sum_a),
    .bus(bus_a.master)
  );

  // Narrow accumulator copy driven in lockstep to exercise saturation
  d_prob_sched #(.T_WIDTH(TW), .N_CLASS(NC), .IDX_W(IW), .SUM_W(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .label(label), .t_cfg(t_cfg),
    .busy(busy_b), .done(done_b), .lbl_err(lbl_err_b), .err_sum(err_sum_b),
    .bus(bus_b.master)
  );

  logic signed [TW:0] score_mem [8];

  // d_prob: p = clamp((T+v)/2, 0, T); d = p for non-target, T-p for target
  function automatic logic [TW-1:0] dp_f(input logic [TW:0] t, input logic [TW:0] q,
                                         input logic signed [TW:0] v);
    int p;
    p = (int'(t) + int'(v)) >>> 1;
    if (p < 0) p = 0;
    if (p > int'(t)) p = int'(t);
    if (q != 0) p = int'(t) - p;
    return TW'(p);
  endfunction

  always @(posedge clk) begin
    if (bus_a.sc_rd_en) bus_a.sc_data <= score_mem[bus_a.sc_addr];
    if (bus_b.sc_rd_en) bus_b.sc_data <= score_mem[bus_b.sc_addr];
    bus_a.dp_d <= dp_f(bus_a.dp_T, bus_a.dp_q, bus_a.dp_v);
    bus_b.dp_d <= dp_f(bus_b.dp_T, bus_b.dp_q, bus_b.dp_v);
  end

  int n_checks = 0;
  int n_fail   = 0;
  int exp_d [NC];
  int beat_idx [$];
  int beat_d [$];
  int lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_scores(input int s0, input int s1, input int s2, input int s3, input int s4);
    score_mem[0] = (TW+1)'(s0);
    score_mem[1] = (TW+1)'(s1);
    score_mem[2] = (TW+1)'(s2);
    score_mem[3] = (TW+1)'(s3);
    score_mem[4] = (TW+1)'(s4);
  endtask

  task automatic set_exp(input int d0, input int d1, input int d2, input int d3, input int d4);
    exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3; exp_d[4] = d4;
  endtask

  // Called #1 after a posedge with the DUT idle; lat counts the start cycle as 1
  task automatic run_pass(input logic [IW-1:0] lab, input logic [TW:0] t, input int stall_idx,
                          input int stall_n, input int poke_at, output int lat_o);
    int stalls;
    stalls = 0;
    beat_idx.delete();
    beat_d.delete();
    start = 1'b1; label = lab; t_cfg = t; out_ready = 1'b1; lat_o = 1;
    @(posedge clk); #1;
    lat_o = 2;
    start = 1'b0;
    while (!done_a && lat_o < 300) begin
      start = (lat_o == poke_at);
      if (start) begin
        label = '0;
        t_cfg = 9'd10;
      end
      out_ready = 1'b1;
      if (bus_a.out_valid) begin
        if (int'(bus_a.out_idx) == stall_idx && stalls < stall_n) begin
          out_ready = 1'b0;
          stalls++;
          check("stall_hold_idx", bus_a.out_idx, stall_idx);
          check("stall_hold_d", bus_a.out_d, exp_d[stall_idx]);
        end else begin
          beat_idx.push_back(int'(bus_a.out_idx));
          beat_d.push_back(int'(bus_a.out_d));
        end
      end
      @(posedge clk); #1;
      lat_o++;
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic check_pass(input string tag, input int lat_i, input int lat_exp, input int nb_exp,
                            input int sum_a, input int sum_b, input int lerr);
    check({tag, "_lat"}, lat_i, lat_exp);
    check({tag, "_nbeats"}, beat_d.size(), nb_exp);
    for (int i = 0; i < beat_d.size() && i < nb_exp; i++) begin
      check($sformatf("%s_idx%0d", tag, i), beat_idx[i], i);
      check($sformatf("%s_d%0d", tag, i), beat_d[i], exp_d[i]);
    end
    check({tag, "_err_sum"}, err_sum_a, sum_a);
    check({tag, "_err_sum_sat"}, err_sum_b, sum_b);
    check({tag, "_lbl_err"}, lbl_err_a, lerr);
    check({tag, "_busy_fin"}, busy_a, 1);
    @(posedge clk); #1;
    check({tag, "_busy_idle"}, busy_a, 0);
    check({tag, "_done_pulse"}, done_a, 0);
    check({tag, "_err_sum_hold"}, err_sum_a, sum_a);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0; label = '0; t_cfg = '0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) score_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_lbl_err", lbl_err_a, 0);
    check("rst_err_sum", err_sum_a, 0);
    check("rst_out_valid", bus_a.out_valid, 0);
    check("rst_sc_rd_en", bus_a.sc_rd_en, 0);
    check("rst_sc_addr", bus_a.sc_addr, 0);
    check("rst_dp_T", bus_a.dp_T, 0);
    check("rst_dp_q", bus_a.dp_q, 0);
    check("rst_dp_v", bus_a.dp_v, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1 basic pass
    set_scores(20, 0, 50, -60, -20);
    set_exp(28, 18, 36, 0, 8);
    run_pass(3'd1, 9'd36, -1, 0, -1, lat);
    check_pass("t1", lat, 27, 5, 90, 63, 0);
    check("t1_dp_T", bus_a.dp_T, 36);

    // T2 consumer stall on idx2
    run_pass(3'd1, 9'd36, 2, 3, -1, lat);
    check_pass("t2", lat, 30, 5, 90, 63, 0);

    // T5 start while busy is ignored
    run_pass(3'd1, 9'd36, -1, 0, 6, lat);
    check_pass("t5", lat, 27, 5, 90, 63, 0);
    check("t5_dp_T", bus_a.dp_T, 36);

    // T3 out-of-range label, then clean pass clears lbl_err
    run_pass(3'd7, 9'd36, -1, 0, -1, lat);
    check_pass("t3", lat, 2, 0, 0, 0, 1);
    set_exp(8, 18, 36, 0, 8);
    run_pass(3'd0, 9'd36, -1, 0, -1, lat);
    check_pass("t3b", lat, 27, 5, 70, 63, 0);

    // T4 reset during idx2 EMIT, then rerun T1
    set_exp(28, 18, 36, 0, 8);
    start = 1'b1; label = 3'd1; t_cfg = 9'd36; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!(bus_a.out_valid && bus_a.out_idx == 3'd2) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("t4_reach_idx2", cyc < 100, 1);
    check("t4_pre_out_d", bus_a.out_d, 36);
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_out_valid", bus_a.out_valid, 0);
    check("t4_rst_busy", busy_a, 0);
    check("t4_rst_out_d", bus_a.out_d, 0);
    check("t4_rst_out_idx", bus_a.out_idx, 0);
    check("t4_rst_err_sum", err_sum_a, 0);
    check("t4_rst_sc_addr", bus_a.sc_addr, 0);
    check("t4_rst_dp_v", bus_a.dp_v, 0);
    @(posedge clk); #1;
    check("t4_no_done", done_a, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_pass(3'd1, 9'd36, -1, 0, -1, lat);
    check_pass("t4", lat, 27, 5, 90, 63, 0);

    // T6 large d values saturate the narrow accumulator
    set_scores(255, 255, 255, 255, 255);
    set_exp(0, 255, 255, 255, 255);
    run_pass(3'd0, 9'd255, -1, 0, -1, lat);
    check_pass("t6", lat, 27, 5, 1020, 63, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
